// File: rtl/cn_ff_scheduler.sv
// Round-robin scheduler sharing one cn flip-flop among NREQ requesters.
// Issues one {c,n} command per grant, waits SETTLE cycles, samples q and checks it against a tracked expectation.
module cn_ff_scheduler #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic              q,
  output logic              c,
  output logic              n,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              rdata,
  output logic              busy,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, win_s, idx_s;
  logic            found_s;
  logic [1:0]      win_op_s, op_r;
  logic [CW-1:0]   cnt_r;
  logic            exp_r, valid_r;
  logic            c_s, n_s, done_s, busy_s;
  logic [NREQ-1:0] gnt_s;

  // arbitration: first requester at or after ptr (with wrap) wins
  always_comb begin
    found_s  = 1'b0;
    win_s    = '0;
    idx_s    = '0;
    win_op_s = 2'b00;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = PW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win_s == PW'(k)) begin
        win_op_s = op[2*k +: 2];
      end else begin
        win_op_s = win_op_s;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (|req) state_s = S_ISSUE;
        else      state_s = S_IDLE;
      end
      S_ISSUE:  state_s = S_SETTLE;
      S_SETTLE: begin
        if (cnt_r <= CW'(1)) state_s = S_RESP;
        else                 state_s = S_SETTLE;
      end
      S_RESP:   state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // output values for the coming state; registered below so nothing leaks combinationally
  always_comb begin
    c_s    = 1'b0;
    n_s    = 1'b0;
    gnt_s  = '0;
    done_s = 1'b0;
    busy_s = (state_s != S_IDLE);
    case (state_s)
      S_ISSUE: begin
        {c_s, n_s} = win_op_s;
        gnt_s      = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
      end
      S_SETTLE: gnt_s = gnt;
      S_RESP: begin
        gnt_s  = gnt;
        done_s = 1'b1;
      end
      default: gnt_s = '0;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      c       <= 1'b0;
      n       <= 1'b0;
      gnt     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      c       <= c_s;
      n       <= n_s;
      gnt     <= gnt_s;
      done    <= done_s;
      busy    <= busy_s;
    end
  end

  // grant bookkeeping and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
      op_r  <= 2'b00;
      cnt_r <= '0;
    end else begin
      if (state_r == S_IDLE && state_s == S_ISSUE) begin
        ptr_r <= PW'((int'(win_s) + 1) % NREQ);
        op_r  <= win_op_s;
      end
      if (state_r == S_ISSUE) begin
        cnt_r <= CW'(SETTLE);
      end else if (state_r == S_SETTLE) begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  // expected-q tracking, response capture and sticky mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r   <= 1'b0;
      valid_r <= 1'b0;
      rdata   <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (state_r == S_ISSUE) begin
        case (op_r)
          2'b01: begin exp_r <= 1'b0; valid_r <= 1'b1; end
          2'b10: begin exp_r <= 1'b1; valid_r <= 1'b1; end
          2'b11: exp_r <= ~exp_r;
          default: exp_r <= exp_r;
        endcase
      end
      if (state_r == S_RESP) begin
        rdata <= q;
        if (valid_r && (q != exp_r)) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cn_ff_scheduler.sv
// Scoreboard bench for cn_ff_scheduler: a cn flip-flop model drives q, directed ops push hand-computed expectations.
module tb_cn_ff_scheduler;

  localparam int NREQ = 4;
  localparam int ST   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [7:0] op  = 8'd0;
  logic       q, c, n, done, rdata, busy, err;
  logic [3:0] gnt;
  logic       ffq = 1'b0, fq_en = 1'b0, fq_val = 1'b0;

  logic [3:0] r3 = 4'd0;
  logic [7:0] o3 = 8'd0;
  logic       ffq3 = 1'b0;
  logic       c3, n3, done3, rdata3, busy3, err3;
  logic [3:0] gnt3;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign q = fq_en ? fq_val : ffq;

  // cn flip-flop models
  always @(posedge clk) begin
    case ({c, n})
      2'b01: ffq <= 1'b0;
      2'b10: ffq <= 1'b1;
      2'b11: ffq <= ~ffq;
      default: ffq <= ffq;
    endcase
    case ({c3, n3})
      2'b01: ffq3 <= 1'b0;
      2'b10: ffq3 <= 1'b1;
      2'b11: ffq3 <= ~ffq3;
      default: ffq3 <= ffq3;
    endcase
  end

  cn_ff_scheduler #(.NREQ(NREQ), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .q(q),
    .c(c), .n(n), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .err(err)
  );

  cn_ff_scheduler #(.NREQ(NREQ), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .req(r3), .op(o3), .q(ffq3),
    .c(c3), .n(n3), .gnt(gnt3), .done(done3), .rdata(rdata3), .busy(busy3), .err(err3)
  );

  typedef struct {
    int         gi;
    logic       rd;
    logic       er;
    logic [1:0] cn;
    int         dc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
  endtask

  task automatic push(input int gi, input logic rd, input logic er, input logic [1:0] cn, input int dc);
    exp_t e;
    e.gi = gi; e.rd = rd; e.er = er; e.cn = cn; e.dc = dc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("wait_idle");
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo("wait_done");
  endtask

  // one complete operation; frc forces q=0 during RESP
  task automatic run_op(input logic [3:0] r, input logic [7:0] o, input int gi,
                        input logic rd, input logic er, input logic [1:0] cn, input bit frc);
    wait_idle();
    req = r;
    op  = o;
    push(gi, rd, er, cn, cyc + 2 + ST);
    wait_done();
    if (frc) begin fq_en = 1'b1; fq_val = 1'b0; end
    req = 4'd0;
    @(negedge clk);
    fq_en = 1'b0;
  endtask

  // monitor: pops an expectation on every done pulse
  exp_t       me;
  bit         pending = 1'b0;
  int         cn_cnt = 0, cn_cyc = 0;
  logic [1:0] cn_val = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
        cn_cnt  = 0;
        continue;
      end
      if (pending) begin
        chk("rdata", 32'(rdata), 32'(me.rd));
        chk("err",   32'(err),   32'(me.er));
        chk("busy_after_resp", 32'(busy), 32'd0);
        pending = 1'b0;
      end
      if ({c, n} != 2'b00) begin
        cn_cnt++;
        cn_val = {c, n};
        cn_cyc = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          tmo("unexpected_done");
        end else begin
          me = sb.pop_front();
          chk("gnt", 32'(gnt), 32'(4'd1 << me.gi));
          chk("done_cycle", 32'(cyc), 32'(me.dc));
          chk("cn_cycles", 32'(cn_cnt), (me.cn != 2'b00) ? 32'd1 : 32'd0);
          if (me.cn != 2'b00) begin
            chk("cn_value", 32'(cn_val), 32'(me.cn));
            chk("cn_to_done", 32'(cyc - cn_cyc), 32'(ST + 1));
          end
          pending = 1'b1;
        end
        cn_cnt = 0;
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_cn",   32'({c, n}), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    //      req      op            gnt rd   er   cn     force
    run_op(4'b0001, 8'b00000010, 0, 1'b1, 1'b0, 2'b10, 1'b0); // set by r0
    run_op(4'b0010, 8'b00001000, 1, 1'b1, 1'b0, 2'b10, 1'b0); // set by r1, ptr->2
    run_op(4'b0011, 8'b00000000, 0, 1'b1, 1'b0, 2'b00, 1'b0); // late requester wraps to r0
    run_op(4'b0011, 8'b00001100, 1, 1'b0, 1'b0, 2'b11, 1'b0); // then r1, toggle
    run_op(4'b0010, 8'b00001000, 1, 1'b1, 1'b0, 2'b10, 1'b0); // set, exp=1
    run_op(4'b0100, 8'b00000000, 2, 1'b0, 1'b1, 2'b00, 1'b1); // hold, q forced 0 -> err
    run_op(4'b1000, 8'b11000000, 3, 1'b0, 1'b1, 2'b11, 1'b0); // err sticky

    // reset in the middle of an operation
    wait_idle();
    req = 4'b0100;
    op  = 8'b00110000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 4'd0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gnt",  32'(gnt),  32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cn",   32'({c, n}), 32'd0);
    chk("mid_rst_err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'b1010, 8'b11001100, 1, 1'b0, 1'b0, 2'b11, 1'b0); // ptr back at 0; toggle while invalid
    run_op(4'b1000, 8'b11000000, 3, 1'b1, 1'b0, 2'b11, 1'b0); // toggle while invalid, ptr->0

    // fairness: all requesters held, r0 sets first, then toggles
    wait_idle();
    req = 4'b1111;
    op  = 8'b11111110;
    t   = cyc;
    push(0, 1'b1, 1'b0, 2'b10, t + 2 + ST);
    push(1, 1'b0, 1'b0, 2'b11, t + 2 + ST + 4);
    push(2, 1'b1, 1'b0, 2'b11, t + 2 + ST + 8);
    push(3, 1'b0, 1'b0, 2'b11, t + 2 + ST + 12);
    push(0, 1'b1, 1'b0, 2'b11, t + 2 + ST + 16);
    for (int k = 0; k < 5; k++) begin
      wait_done();
      if (k == 0) op = 8'hFF;
      if (k == 4) req = 4'd0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // SETTLE=3 instance: done at E+4+1, c/n only in E+1
    r3 = 4'b0001;
    o3 = 8'b00000010;
    t  = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        chk("s3_done", 32'(done3), (cyc == t + 5) ? 32'd1 : 32'd0);
        chk("s3_cn", 32'({c3, n3}), (cyc == t + 1) ? 32'd2 : 32'd0);
      end else begin
        chk("s3_rdata", 32'(rdata3), 32'd1);
        chk("s3_busy", 32'(busy3), 32'd0);
      end
      if (done3) r3 = 4'd0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
